alpha_iter_buffer: RTL and testbench

Parametrised column-collect / symbol-replay buffer for the iterative alpha update loop. It accepts J normalised alpha columns, each holding I rows × A symbols, and converts them to output width with saturation and zero-clamp. Once all J columns are stored it replays them symbol-by-symbol with an AXI-stream handshake, which feeds the next iteration of the cal-core array. It counts iterations and stops after MAX_ITER, so the top level needs no ad-hoc new-iteration/replay logic.

---
 rtl/alpha_iter_buffer.sv | 185 ++++++++++++++++++
 tb/tb_alpha_iter_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_iter_buffer.sv
// alpha_iter_buffer
// Collects J normalised alpha columns (I rows x A symbols each), converts every
// value to DW bits with saturation and an optional zero-clamp, then replays the
// stored matrix one symbol per beat over an AXI-stream style handshake. After
// MAX_ITER complete replays the block parks in DONE until reset.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   s_col_*           column input; row i symbol a at [(i*A+a)*IN_W +: IN_W]
//   m_*               replay output; row i column j at [(i*J+j)*DW +: DW]
//   m_sym_idx         symbol index of the current beat
//   iter_start        one-cycle pulse on the first replay beat of an iteration
//   iter_cnt          completed iterations
//   done              MAX_ITER iterations completed
//   err_drop          sticky: a column was offered while in DONE
//
// state  | meaning
// -------+-----------------------------------------------------------
// FILL   | accepting columns, col_idx selects the column written
// REPLAY | presenting beat `beat` of the stored matrix downstream
// DONE   | iteration budget spent, inputs refused until reset

module alpha_iter_buffer #(
    parameter int J          = 14,
    parameter int I          = 7,
    parameter int A          = 2,
    parameter int IN_W       = 8,
    parameter int DW         = 8,
    parameter int MAX_ITER   = 8,
    parameter int CLAMP_ZERO = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [I*A*IN_W-1:0]           s_col_tdata,
    input  logic                          s_col_tvalid,
    output logic                          s_col_tready,
    output logic [I*J*DW-1:0]             m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [$clog2(A):0]            m_sym_idx,
    output logic                          iter_start,
    output logic [$clog2(MAX_ITER):0]     iter_cnt,
    output logic                          done,
    output logic                          err_drop
);

    localparam int CW  = $clog2(J);
    localparam int SW  = $clog2(A);
    localparam int BW  = $clog2(A) + 1;
    localparam int ICW = $clog2(MAX_ITER) + 1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_REPLAY = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col_idx;
    logic [BW-1:0]   beat;
    logic [DW-1:0]   buf_mem [I][J][A];

    logic            col_acc;
    logic            last_col;
    logic            beat_hs;
    logic            last_beat;
    logic [ICW-1:0]  iter_cnt_inc;

    // Saturate first, then clamp: only a true zero input becomes 1.
    function automatic logic [DW-1:0] conv(input logic [IN_W-1:0] v);
        logic over;
        over = 1'b0;
        for (int b = DW; b < IN_W; b++) begin
            over = over | v[b];
        end
        if (over) begin
            conv = '1;
        end else if ((CLAMP_ZERO != 0) && (v == '0)) begin
            conv = DW'(1);
        end else begin
            conv = v[DW-1:0];
        end
    endfunction

    // Ready is high for the whole of FILL, so valid alone marks an accept.
    assign col_acc      = (state == ST_FILL) && s_col_tvalid;
    assign last_col     = (col_idx == CW'(J - 1));
    assign beat_hs      = (state == ST_REPLAY) && m_tready;
    assign last_beat    = (beat == BW'(A - 1));
    assign iter_cnt_inc = iter_cnt + ICW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        s_col_tready = 1'b0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        done         = 1'b0;
        m_sym_idx    = beat;
        case (state)
            ST_FILL: begin
                s_col_tready = 1'b1;
                if (col_acc && last_col) begin
                    state_nxt = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                m_tvalid = 1'b1;
                m_tlast  = last_beat;
                if (beat_hs && last_beat) begin
                    state_nxt = (iter_cnt_inc == ICW'(MAX_ITER)) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = ST_FILL;
            end
        endcase
    end

    // Beat mux; driven to zero outside REPLAY so idle outputs stay quiet.
    always_comb begin
        m_tdata = '0;
        if (state == ST_REPLAY) begin
            for (int i = 0; i < I; i++) begin
                for (int j = 0; j < J; j++) begin
                    m_tdata[(i*J+j)*DW +: DW] = buf_mem[i][j][beat[SW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx    <= '0;
            beat       <= '0;
            iter_cnt   <= '0;
            iter_start <= 1'b0;
            err_drop   <= 1'b0;
            for (int i = 0; i < I; i++) begin
                for (int j = 0; j < J; j++) begin
                    for (int a = 0; a < A; a++) begin
                        buf_mem[i][j][a] <= '0;
                    end
                end
            end
        end else begin
            iter_start <= col_acc && last_col;

            if (col_acc) begin
                for (int i = 0; i < I; i++) begin
                    for (int a = 0; a < A; a++) begin
                        buf_mem[i][col_idx][a] <= conv(s_col_tdata[(i*A+a)*IN_W +: IN_W]);
                    end
                end
                col_idx <= last_col ? '0 : col_idx + CW'(1);
            end

            if (beat_hs) begin
                if (last_beat) begin
                    beat     <= '0;
                    iter_cnt <= iter_cnt_inc;
                end else begin
                    beat <= beat + BW'(1);
                end
            end

            if ((state == ST_DONE) && s_col_tvalid) begin
                err_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alpha_iter_buffer.sv
// tb_alpha_iter_buffer
// Drives two alpha_iter_buffer instances in lockstep (zero-clamp on and off)
// with directed fill/replay sequences carrying random column data, and checks
// every output against a matrix-level reference model of the stored values.

module tb_alpha_iter_buffer;

    localparam int TJ   = 3;
    localparam int TI   = 2;
    localparam int TA   = 2;
    localparam int TIN  = 10;
    localparam int TDW  = 8;
    localparam int TMI  = 2;
    localparam int SIW  = $clog2(TA) + 1;
    localparam int ICW  = $clog2(TMI) + 1;
    localparam int VMAX = (1 << TDW) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [TI*TA*TIN-1:0]    s_col_tdata;
    logic                    s_col_tvalid;
    logic                    m_tready;

    logic                    s_col_tready_c, s_col_tready_n;
    logic [TI*TJ*TDW-1:0]    m_tdata_c, m_tdata_n;
    logic                    m_tvalid_c, m_tvalid_n;
    logic                    m_tlast_c, m_tlast_n;
    logic [SIW-1:0]          m_sym_idx_c, m_sym_idx_n;
    logic                    iter_start_c, iter_start_n;
    logic [ICW-1:0]          iter_cnt_c, iter_cnt_n;
    logic                    done_c, done_n;
    logic                    err_drop_c, err_drop_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: converted matrix contents for each clamp setting.
    int exp_c [TI][TJ][TA];
    int exp_n [TI][TJ][TA];
    int raw   [TI][TA];
    int m_iter;

    always #5 clk = ~clk;

    alpha_iter_buffer #(
        .J(TJ), .I(TI), .A(TA), .IN_W(TIN), .DW(TDW), .MAX_ITER(TMI), .CLAMP_ZERO(1)
    ) dut_c (
        .clk(clk), .rst(rst),
        .s_col_tdata(s_col_tdata), .s_col_tvalid(s_col_tvalid), .s_col_tready(s_col_tready_c),
        .m_tdata(m_tdata_c), .m_tvalid(m_tvalid_c), .m_tready(m_tready), .m_tlast(m_tlast_c),
        .m_sym_idx(m_sym_idx_c), .iter_start(iter_start_c), .iter_cnt(iter_cnt_c),
        .done(done_c), .err_drop(err_drop_c)
    );

    alpha_iter_buffer #(
        .J(TJ), .I(TI), .A(TA), .IN_W(TIN), .DW(TDW), .MAX_ITER(TMI), .CLAMP_ZERO(0)
    ) dut_n (
        .clk(clk), .rst(rst),
        .s_col_tdata(s_col_tdata), .s_col_tvalid(s_col_tvalid), .s_col_tready(s_col_tready_n),
        .m_tdata(m_tdata_n), .m_tvalid(m_tvalid_n), .m_tready(m_tready), .m_tlast(m_tlast_n),
        .m_sym_idx(m_sym_idx_n), .iter_start(iter_start_n), .iter_cnt(iter_cnt_n),
        .done(done_n), .err_drop(err_drop_n)
    );

    function automatic int conv_ref(int v, bit clamp);
        if (v > VMAX) return VMAX;
        if (v == 0 && clamp) return 1;
        return v;
    endfunction

    function automatic logic [63:0] exp_data(int b, bit clamp);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < TI; i++) begin
            for (int j = 0; j < TJ; j++) begin
                r[(i*TJ+j)*TDW +: TDW] = TDW'(clamp ? exp_c[i][j][b] : exp_n[i][j][b]);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TI; i++)
            for (int j = 0; j < TJ; j++)
                for (int a = 0; a < TA; a++) begin
                    exp_c[i][j][a] = 0;
                    exp_n[i][j][a] = 0;
                end
        m_iter = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready_c"},  64'(s_col_tready_c), 64'd1);
        chk({tag, "_tready_n"},  64'(s_col_tready_n), 64'd1);
        chk({tag, "_tvalid_c"},  64'(m_tvalid_c),     64'd0);
        chk({tag, "_tvalid_n"},  64'(m_tvalid_n),     64'd0);
        chk({tag, "_tlast"},     64'(m_tlast_c),      64'd0);
        chk({tag, "_sym_idx"},   64'(m_sym_idx_c),    64'd0);
        chk({tag, "_tdata_c"},   64'(m_tdata_c),      64'd0);
        chk({tag, "_tdata_n"},   64'(m_tdata_n),      64'd0);
        chk({tag, "_iter_start"},64'(iter_start_c),   64'd0);
        chk({tag, "_iter_cnt"},  64'(iter_cnt_c),     64'd0);
        chk({tag, "_done"},      64'(done_c),         64'd0);
        chk({tag, "_err_drop_c"},64'(err_drop_c),     64'd0);
        chk({tag, "_err_drop_n"},64'(err_drop_n),     64'd0);
    endtask

    task automatic push_col(input int j);
        for (int i = 0; i < TI; i++)
            for (int a = 0; a < TA; a++)
                s_col_tdata[(i*TA+a)*TIN +: TIN] = TIN'(raw[i][a]);
        s_col_tvalid = 1'b1;
        chk($sformatf("fill_tready_c%0d", j), 64'(s_col_tready_c), 64'd1);
        chk($sformatf("fill_tvalid_c%0d", j), 64'(m_tvalid_c),     64'd0);
        @(posedge clk); #1;
        s_col_tvalid = 1'b0;
        for (int i = 0; i < TI; i++)
            for (int a = 0; a < TA; a++) begin
                exp_c[i][j][a] = conv_ref(raw[i][a], 1'b1);
                exp_n[i][j][a] = conv_ref(raw[i][a], 1'b0);
            end
    endtask

    task automatic rand_col();
        for (int i = 0; i < TI; i++)
            for (int a = 0; a < TA; a++)
                raw[i][a] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
    endtask

    task automatic fill_random();
        for (int j = 0; j < TJ; j++) begin
            rand_col();
            push_col(j);
        end
    endtask

    task automatic check_beat(input string tag, input int b, input bit exp_is);
        chk({tag, "_tvalid"},    64'(m_tvalid_c),     64'd1);
        chk({tag, "_tready_in"}, 64'(s_col_tready_c), 64'd0);
        chk({tag, "_sym_idx"},   64'(m_sym_idx_c),    64'(b));
        chk({tag, "_sym_idx_n"}, 64'(m_sym_idx_n),    64'(b));
        chk({tag, "_tlast"},     64'(m_tlast_c),      64'(b == TA - 1));
        chk({tag, "_iter_start"},64'(iter_start_c),   64'(exp_is));
        chk({tag, "_tdata_c"},   64'(m_tdata_c),      exp_data(b, 1'b1));
        chk({tag, "_tdata_n"},   64'(m_tdata_n),      exp_data(b, 1'b0));
    endtask

    // Entered one cycle after the last column was accepted.
    task automatic replay(input int stall);
        for (int b = 0; b < TA; b++) begin
            if (b == 0) begin
                m_tready = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    check_beat($sformatf("stall%0d", k), 0, k == 0);
                    @(posedge clk); #1;
                end
            end
            m_tready = 1'b1;
            check_beat($sformatf("it%0d_beat%0d", m_iter, b), b, (b == 0) && (stall == 0));
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
        m_iter++;
        chk("iter_cnt_c", 64'(iter_cnt_c), 64'(m_iter));
        chk("iter_cnt_n", 64'(iter_cnt_n), 64'(m_iter));
        chk("post_tvalid", 64'(m_tvalid_c), 64'd0);
        chk("post_done",   64'(done_c),     64'(m_iter == TMI));
        chk("post_tready", 64'(s_col_tready_c), 64'(m_iter != TMI));
    endtask

    initial begin
        rst          = 1'b1;
        s_col_tvalid = 1'b0;
        s_col_tdata  = '0;
        m_tready     = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Iteration 1: recognisable pattern, backpressure on beat 0.
        for (int j = 0; j < TJ; j++) begin
            for (int i = 0; i < TI; i++)
                for (int a = 0; a < TA; a++)
                    raw[i][a] = 10*j + i + a + 1;
            push_col(j);
        end
        chk("slot_r1c2_b0", 64'(m_tdata_c[(1*TJ+2)*TDW +: TDW]), 64'd22);
        replay(5);

        // Iteration 2: conversion corner values in column 0, random elsewhere.
        rand_col();
        raw[0][0] = 0;
        raw[0][1] = 300;
        raw[1][0] = 255;
        raw[1][1] = 7;
        push_col(0);
        for (int j = 1; j < TJ; j++) begin
            rand_col();
            push_col(j);
        end
        replay(int'($urandom_range(0, 3)));

        // DONE: offered column is refused and flagged.
        s_col_tdata  = TI*TA*TIN'($urandom);
        s_col_tvalid = 1'b1;
        @(posedge clk); #1;
        s_col_tvalid = 1'b0;
        chk("drop_err_c",  64'(err_drop_c),     64'd1);
        chk("drop_err_n",  64'(err_drop_n),     64'd1);
        chk("drop_tready", 64'(s_col_tready_c), 64'd0);
        chk("drop_tvalid", 64'(m_tvalid_c),     64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("sticky_err",  64'(err_drop_c),     64'd1);
        chk("sticky_done", 64'(done_c),         64'd1);
        chk("sticky_iter", 64'(iter_cnt_c),     64'(TMI));

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_reset_outputs("rst_done");

        // Reset in the middle of a replay.
        fill_random();
        m_tready = 1'b1;
        check_beat("mid_beat0", 0, 1'b1);
        @(posedge clk); #1;
        m_tready = 1'b0;
        chk("mid_sym_idx", 64'(m_sym_idx_c), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_reset_outputs("rst_mid");

        // Fresh data after the reset, then a full refill over it.
        fill_random();
        replay(0);
        fill_random();
        replay(int'($urandom_range(1, 4)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
